// File: rtl/ram8_pkg.sv
// ============================================================================
//  Module   : ram8_pkg
//  Purpose  : Shared word width and sizing helpers for the Hack memory stack
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ram8_pkg;

    localparam int WORD_WIDTH      = 16;
    localparam int RAM8_ADDR_WIDTH = 3;
    localparam int RAM8_DEPTH      = 8;

    // A bank is only fully decoded when every address code selects a word.
    function automatic bit depth_matches(input int depth, input int addr_width);
        return depth == (1 << addr_width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
//  Module   : dff
//  Purpose  : Single-bit clocked storage element with async active-low clear
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dff (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic bit_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= d_i;
        end
    end

    assign q_o = bit_q;

endmodule

`default_nettype wire

// File: rtl/word_register.sv
// ============================================================================
//  Module   : word_register
//  Purpose  : WIDTH-bit register built from dff cells with a per-bit load mux
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module word_register
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] word_d;

    // Holding is done by recirculating each bit, so the dff itself has no enable.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign word_d[i] = load ? in[i] : out[i];

        dff u_dff (
            .clock   (clock),
            .reset_n (reset_n),
            .d_i     (word_d[i]),
            .q_o     (out[i])
        );
    end

endmodule

`default_nettype wire

// File: rtl/ram8.sv
// ============================================================================
//  Module   : ram8
//  Purpose  : Eight-word bank: combinational read, clocked write, async clear
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram8
    import ram8_pkg::*;
#(
    parameter int WIDTH      = WORD_WIDTH,
    parameter int ADDR_WIDTH = RAM8_ADDR_WIDTH,
    parameter int DEPTH      = RAM8_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [WIDTH-1:0]      out
);

    if (!depth_matches(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "ram8: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [DEPTH-1:0] word_load;
    logic [WIDTH-1:0] word_out [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        assign word_load[k] = load && (address == ADDR_WIDTH'(k));

        word_register #(
            .WIDTH (WIDTH)
        ) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .in      (in),
            .load    (word_load[k]),
            .out     (word_out[k])
        );
    end

    // Full decode means address always lands on a real word.
    assign out = word_out[address];

endmodule

`default_nettype wire

// File: tb/tb_ram8.sv
// ============================================================================
//  Module   : tb_ram8
//  Purpose  : Directed and randomized self-checking bench for ram8
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram8;

    localparam int c_W = 16;
    localparam int c_A = 3;
    localparam int c_D = 8;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           load;
    logic [c_W-1:0] in;
    logic [c_A-1:0] address;
    logic [c_W-1:0] out;

    int checks = 0;
    int errors = 0;

    logic [c_W-1:0] mem [c_D];

    ram8 #(
        .WIDTH      (c_W),
        .ADDR_WIDTH (c_A),
        .DEPTH      (c_D)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [c_W-1:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (addr %0d, t=%0t)", tag, out, exp, address, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_D; i++) mem[i] = '0;
    endtask

    // Advance through one rising edge; the memory model records what the edge writes.
    task automatic tick();
        @(posedge clock);
        if (reset_n === 1'b1 && load === 1'b1) mem[address] = in;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        in      = '0;
        address = '0;
        model_clear();

        #1 check("reset_out", 16'h0000);
        #1 reset_n = 1'b1;

        #5;
        address = 3'd3; in = 16'hBEEF; load = 1'b1;
        tick();
        load = 1'b0;
        check("beef_write", 16'hBEEF);

        #1;
        address = 3'd5; in = 16'h1234; load = 1'b1;
        #1 check("latency_t18", 16'h0000);
        #6 check("latency_t24", 16'h0000);
        tick();
        check("latency_t26", 16'h1234);
        load = 1'b0;

        #5 address = 3'd3;
        #1 reset_n = 1'b0;
        model_clear();
        #1 check("async_clear_addr3", 16'h0000);
        load = 1'b1; in = 16'hFFFF;
        for (int i = 0; i < c_D; i++) begin
            address = c_A'(i);
            #1 check("reset_sweep", 16'h0000);
        end
        load = 1'b0;
        reset_n = 1'b1;

        for (int a = 0; a < c_D; a++) begin
            @(negedge clock);
            address = c_A'(a); in = 16'h0100 + 16'(a); load = 1'b1;
            tick();
        end
        load = 1'b0; in = 16'hFFFF;
        repeat (3) begin
            @(negedge clock);
            address = c_A'($urandom_range(0, c_D - 1));
            tick();
        end
        for (int a = 0; a < c_D; a++) begin
            address = c_A'(a);
            #1 check("hold_readback", 16'h0100 + 16'(a));
        end

        @(negedge clock);
        address = 3'd2;
        #1 check("comb_read_a2", 16'h0102);
        address = 3'd6;
        #1 check("comb_read_a6", 16'h0106);

        @(negedge clock);
        address = 3'd4; in = 16'hAAAA; load = 1'b1;
        #3 check("rdw_before", 16'h0104);
        tick();
        check("rdw_after", 16'hAAAA);
        load = 1'b0;
        address = 3'd3;
        #1 check("rdw_neighbour3", 16'h0103);
        address = 3'd5;
        #1 check("rdw_neighbour5", 16'h0105);

        @(negedge clock);
        #3;
        load = 1'b1; in = 16'h5555; address = 3'd1;
        reset_n = 1'b0;
        model_clear();
        #4 reset_n = 1'b1;
        #1 check("midrst_blocked", 16'h0000);
        tick();
        check("midrst_first_write", 16'h5555);
        load = 1'b0;

        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            address = c_A'($urandom_range(0, c_D - 1));
            in      = c_W'($urandom);
            load    = 1'($urandom_range(0, 1));
            #1 check("rand_pre_edge", mem[address]);
            if ($urandom_range(0, 19) == 0) begin
                reset_n = 1'b0;
                model_clear();
                #1 check("rand_async_clear", 16'h0000);
                reset_n = 1'b1;
            end
            tick();
            check("rand_post_edge", mem[address]);
            address = c_A'($urandom_range(0, c_D - 1));
            #1 check("rand_comb_read", mem[address]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
